apb_master_bridge: RTL and testbench

APB requester that converts a simple valid/ready command stream into APB4 transfers and returns each transfer's result on a valid/ready response channel. It sits directly upstream of the APB slave and register file wrapper and drives its PSELx/PADDR/PWRITE/PSTRB/PWDATA/PENABLE inputs. It consumes that wrapper's PRDATA/PREADY. A wait-state timeout reports an error response if the slave never completes.

---
 rtl/apb_master_bridge.sv | 153 +++++++++++++++
 tb/tb_apb_master_bridge.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
// APB4 requester: turns a valid/ready command stream into single APB transfers
// and returns each result (read data or timeout error) on a valid/ready response channel.
module apb_master_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NBYTES     = DATA_WIDTH / 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [NBYTES-1:0]     cmd_strb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [NBYTES-1:0]     PSTRB,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                  state_q, state_d;
  logic                    cmd_en_q;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [NBYTES-1:0]       pstrb_q, pstrb_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [CW-1:0]           wait_cnt_q, wait_cnt_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

  // cmd_en_q keeps cmd_ready low while PRESET is asserted and until the first edge after release
  assign cmd_ready = cmd_en_q && (state_q == IDLE) && !rsp_valid_q;

  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PSTRB     = pstrb_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      cmd_en_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_en_q    <= 1'b1;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    // Data and error fields stay put after the handshake; only valid drops.
    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = cmd_addr;
          pwrite_d  = cmd_write;
          pstrb_d   = cmd_write ? cmd_strb : '0;
          pwdata_d  = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
        end else if (wait_cnt_q == CNT_LAST) begin
          // Slave stalled for TIMEOUT access cycles: abandon and flag the error.
          state_d     = IDLE;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench: randomized APB transfers against a word-memory slave model
// and a transfer-level expectation of timing, stability, responses and resets.
module tb_apb_master_bridge;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NB = 4;
  localparam int TO = 16;

  logic          PCLK;
  logic          PRESET;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [NB-1:0] cmd_strb;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          PSELx;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [NB-1:0] PSTRB;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;

  apb_master_bridge #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NBYTES    (NB),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .cmd_strb (cmd_strb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PADDR    (PADDR),
    .PSTRB    (PSTRB),
    .PWDATA   (PWDATA),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Slave memory model: 16 words, word index = addr[5:2].
  logic [31:0] mem [16];
  int n_checks;
  int n_err;
  int n_xfer;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_apb(input string ph, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input bit pen);
    chk({ph, ".psel"},      32'(PSELx), 1);
    chk({ph, ".penable"},   32'(PENABLE), 32'(pen));
    chk({ph, ".paddr"},     PADDR, addr);
    chk({ph, ".pwrite"},    32'(PWRITE), 32'(wr));
    chk({ph, ".pstrb"},     32'(PSTRB), wr ? 32'(strb) : 0);
    chk({ph, ".pwdata"},    PWDATA, wr ? wdata : 0);
    chk({ph, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({ph, ".cmd_ready"}, 32'(cmd_ready), 0);
  endtask

  // Asynchronous reset away from any clock edge; nothing may respond afterwards.
  task automatic async_reset(input string tag);
    #2;
    PRESET = 1'b1;
    #1;
    chk({tag, ".rst_psel"},      32'(PSELx), 0);
    chk({tag, ".rst_penable"},   32'(PENABLE), 0);
    chk({tag, ".rst_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".rst_cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, ".rst_paddr"},     PADDR, 0);
    chk({tag, ".rst_rdata"},     rsp_rdata, 0);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    repeat (2) @(negedge PCLK);
    PRESET = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge PCLK);
      chk({tag, ".post_rsp_valid"}, 32'(rsp_valid), 0);
      chk({tag, ".post_psel"},      32'(PSELx), 0);
      PREADY = 1'($urandom);
      PRDATA = $urandom;
    end
    rsp_ready = 1'b1;
  endtask

  // One complete transfer. abort_at >= 0: reset in that ACCESS cycle;
  // abort_at == -2: reset while the response is still pending.
  task automatic do_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input int rdelay,
                         input int abort_at);
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          k_end;
    int          idx;
    idx = int'(addr[5:2]);
    n_xfer++;
    chk("idle.cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    cmd_strb  = 4'($urandom);
    chk_apb("setup", wr, addr, wdata, strb, 1'b0);
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    exp_err = (waits >= TO);
    k_end   = exp_err ? TO - 1 : waits;
    for (int k = 0; k <= k_end; k++) begin
      @(negedge PCLK);
      chk_apb("access", wr, addr, wdata, strb, 1'b1);
      if (k == abort_at) begin
        async_reset("abort_access");
        $display("xfer %0d %s addr=%h aborted by reset in access cycle %0d",
                 n_xfer, wr ? "WR" : "RD", addr, k);
        return;
      end
      PREADY = (k == waits);
      PRDATA = (!wr && k == waits) ? mem[idx] : $urandom;
    end
    exp_rdata = (wr || exp_err) ? 32'h0 : mem[idx];
    if (wr && !exp_err) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end
    @(negedge PCLK);
    PREADY = 1'($urandom);
    PRDATA = $urandom;
    chk("done.psel",      32'(PSELx), 0);
    chk("done.penable",   32'(PENABLE), 0);
    chk("done.rsp_valid", 32'(rsp_valid), 1);
    chk("done.rsp_err",   32'(rsp_err), 32'(exp_err));
    chk("done.rsp_rdata", rsp_rdata, exp_rdata);
    chk("done.cmd_ready", 32'(cmd_ready), 0);
    chk("done.paddr",     PADDR, addr);
    chk("done.pstrb",     32'(PSTRB), wr ? 32'(strb) : 0);
    if (abort_at == -2) begin
      async_reset("abort_rsp");
      $display("xfer %0d %s addr=%h response discarded by reset", n_xfer, wr ? "WR" : "RD", addr);
      return;
    end
    rsp_ready = (rdelay == 0);
    cmd_valid = (rdelay > 0);
    for (int d = 1; d <= rdelay; d++) begin
      @(negedge PCLK);
      chk("bp.rsp_valid", 32'(rsp_valid), 1);
      chk("bp.rsp_err",   32'(rsp_err), 32'(exp_err));
      chk("bp.rsp_rdata", rsp_rdata, exp_rdata);
      chk("bp.cmd_ready", 32'(cmd_ready), 0);
      chk("bp.psel",      32'(PSELx), 0);
      rsp_ready = (d == rdelay);
    end
    @(negedge PCLK);
    chk("hs.rsp_valid", 32'(rsp_valid), 0);
    chk("hs.rsp_err",   32'(rsp_err), 32'(exp_err));
    chk("hs.rsp_rdata", rsp_rdata, exp_rdata);
    cmd_valid = 1'b0;
    rsp_ready = 1'($urandom);
    $display("xfer %0d %s addr=%h wdata=%h strb=%h waits=%0d rdelay=%0d err=%0d rdata=%h",
             n_xfer, wr ? "WR" : "RD", addr, wdata, strb, waits, rdelay, exp_err, exp_rdata);
  endtask

  initial begin
    int          waits;
    int          rdelay;
    int          sel;
    bit          wr;
    logic [3:0]  widx;
    n_checks = 0;
    n_err    = 0;
    n_xfer   = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    PRESET    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h4;
    cmd_wdata = 32'h1;
    cmd_strb  = 4'hF;
    rsp_ready = 1'b0;
    PREADY    = 1'b1;
    PRDATA    = 32'h0;
    repeat (2) @(negedge PCLK);
    chk("reset.cmd_ready", 32'(cmd_ready), 0);
    chk("reset.psel",      32'(PSELx), 0);
    chk("reset.penable",   32'(PENABLE), 0);
    chk("reset.pwrite",    32'(PWRITE), 0);
    chk("reset.paddr",     PADDR, 0);
    chk("reset.pstrb",     32'(PSTRB), 0);
    chk("reset.pwdata",    PWDATA, 0);
    chk("reset.rsp_valid", 32'(rsp_valid), 0);
    chk("reset.rsp_err",   32'(rsp_err), 0);
    chk("reset.rsp_rdata", rsp_rdata, 0);
    cmd_valid = 1'b0;
    PRESET    = 1'b0;
    repeat (2) @(negedge PCLK);
    rsp_ready = 1'b1;

    // Directed cases from the test plan
    do_xfer(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, 0, -1);
    do_xfer(1'b0, 32'h4, 32'h5555AAAA, 4'hE, 0, 0, -1);
    do_xfer(1'b1, 32'h8, 32'h12345678, 4'hF, 0, 0, -1);
    do_xfer(1'b0, 32'h8, 32'h0,        4'h0, 3, 0, -1);
    do_xfer(1'b0, 32'h10, 32'h0,       4'h0, 1000, 0, -1);
    do_xfer(1'b0, 32'h10, 32'h0,       4'h0, TO - 1, 0, -1);
    do_xfer(1'b1, 32'h14, 32'h0BADF00D, 4'hF, TO, 1, -1);
    do_xfer(1'b1, 32'h18, 32'hCAFEF00D, 4'h3, 1, 5, -1);
    do_xfer(1'b1, 32'hC, 32'hAABBCCDD, 4'h5, 0, 0, -1);
    do_xfer(1'b0, 32'hC, 32'hFFFFFFFF, 4'hF, 2, 0, -1);
    do_xfer(1'b1, 32'h20, 32'h11112222, 4'hF, 10, 0, 2);
    do_xfer(1'b0, 32'h20, 32'h0,       4'h0, 0, 0, -1);
    do_xfer(1'b0, 32'h24, 32'h0,       4'h0, 1, 3, -2);
    do_xfer(1'b0, 32'h24, 32'h0,       4'h0, 0, 0, -1);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      waits = int'($urandom_range(0, 3));
      else if (sel < 8) waits = int'($urandom_range(TO - 2, TO + 2));
      else              waits = int'($urandom_range(4, 12));
      rdelay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
      wr     = 1'($urandom);
      widx   = 4'($urandom);
      do_xfer(wr, {26'h0, widx, 2'b00}, $urandom, 4'($urandom), waits, rdelay, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
